// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Purpose  : Shares the 16-bit packed-BCD bus feeding a 4-digit seven-segment
//            scanner between the live value and a one-shot message source.
//            Messages arrive on a req/ack handshake, are held on the display
//            for HOLD_FRAMES full scan frames, and the displayed source only
//            ever changes on a scan-frame boundary so no frame mixes digits.
// Ports    : clk          - system clock, rising edge
//            rst          - synchronous active-high reset
//            live_bcd     - live value, 4 BCD digits, [3:0] = ones digit
//            msg_bcd      - message value, sampled only when accepted
//            msg_req      - level request, held by requester until msg_ack
//            msg_cancel   - abort a pending or displayed message
//            msg_ack      - 1-cycle pulse, message accepted and latched
//            msg_done     - 1-cycle pulse, message finished or cancelled
//            msg_active   - high while the message is driven on bcd_out
//            frame_tick   - 1-cycle pulse on the last cycle of a scan frame
//            bcd_out      - packed-BCD value to the anode scanner
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int FRAME_CYCLES = 4096,
    parameter int HOLD_FRAMES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] live_bcd,
    input  logic [15:0] msg_bcd,
    input  logic        msg_req,
    input  logic        msg_cancel,
    output logic        msg_ack,
    output logic        msg_done,
    output logic        msg_active,
    output logic        frame_tick,
    output logic [15:0] bcd_out
);

    localparam int CNT_W  = $clog2(FRAME_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_FRAMES) + 1;

    localparam logic [CNT_W-1:0]  c_frame_last = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_last  = HOLD_W'(HOLD_FRAMES - 1);

    localparam logic [1:0] S_LIVE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_MSG  = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_cancel_pend;
    logic [15:0]       r_msg_reg;
    logic              r_ack;
    logic              r_done;
    logic              r_active;
    logic [15:0]       r_bcd;

    logic              w_tick;
    logic [1:0]        w_next_state;
    logic              w_accept;
    logic              w_done;

    // Tick is forced low while rst is asserted so nothing downstream sees a
    // frame boundary from a counter that is about to be cleared.
    assign w_tick = !rst && (r_frame_cnt == c_frame_last);

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_LIVE: begin
                if (msg_req) begin
                    w_next_state = S_PEND;
                    w_accept     = 1'b1;
                end
            end
            S_PEND: begin
                // Cancel wins over a coincident tick: the message is never shown.
                if (msg_cancel) begin
                    w_next_state = S_LIVE;
                    w_done       = 1'b1;
                end else if (w_tick) begin
                    w_next_state = S_MSG;
                end
            end
            S_MSG: begin
                // Leave only on a frame boundary; a cancel seen on the tick
                // itself, an earlier latched cancel and the natural end all
                // collapse into the same single exit.
                if (w_tick && ((r_hold_cnt == c_hold_last) || r_cancel_pend || msg_cancel)) begin
                    w_next_state = S_LIVE;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_next_state = S_LIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_LIVE;
            r_frame_cnt   <= '0;
            r_hold_cnt    <= '0;
            r_cancel_pend <= 1'b0;
            r_msg_reg     <= '0;
            r_ack         <= 1'b0;
            r_done        <= 1'b0;
            r_active      <= 1'b0;
            r_bcd         <= '0;
        end else begin
            r_frame_cnt <= w_tick ? '0 : r_frame_cnt + 1'b1;
            r_state     <= w_next_state;
            r_ack       <= w_accept;
            r_done      <= w_done;

            if (w_accept) begin
                r_msg_reg <= msg_bcd;
            end

            // Output mux follows the next state so bcd_out and msg_active
            // switch on the same edge.
            r_active <= (w_next_state == S_MSG);
            r_bcd    <= (w_next_state == S_MSG) ? r_msg_reg : live_bcd;

            if ((r_state == S_PEND) && (w_next_state == S_MSG)) begin
                r_hold_cnt <= '0;
            end else if ((r_state == S_MSG) && w_tick && (w_next_state == S_MSG)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            // A mid-frame cancel is remembered until the next frame boundary.
            if (w_next_state != S_MSG) begin
                r_cancel_pend <= 1'b0;
            end else if ((r_state == S_MSG) && msg_cancel) begin
                r_cancel_pend <= 1'b1;
            end
        end
    end

    assign msg_ack    = r_ack;
    assign msg_done   = r_done;
    assign msg_active = r_active;
    assign frame_tick = w_tick;
    assign bcd_out    = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_arbiter
// Purpose  : Self-checking bench for seg_display_arbiter with FRAME_CYCLES=8,
//            HOLD_FRAMES=2. The reference model works on absolute cycle
//            numbers since reset: a message accepted in cycle a is visible
//            from the cycle after the first frame-end at or after a+1, for
//            HOLD*FRAME cycles, cut short to the next frame-end on cancel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

    localparam int FRAME = 8;
    localparam int HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] live_bcd = '0;
    logic [15:0] msg_bcd = '0;
    logic        msg_req = 1'b0;
    logic        msg_cancel = 1'b0;
    logic        msg_ack;
    logic        msg_done;
    logic        msg_active;
    logic        frame_tick;
    logic [15:0] bcd_out;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          k = 0;        // cycle index since the last reset edge
    bit          m_has = 1'b0; // a message is pending or on display
    logic [15:0] m_msg = '0;
    int          m_first = 0;  // first visible cycle
    int          m_last = 0;   // last visible cycle
    logic        e_ack = 1'b0;
    logic        e_done = 1'b0;
    logic        e_act = 1'b0;
    logic [15:0] e_bcd = '0;

    seg_display_arbiter #(
        .FRAME_CYCLES(FRAME),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .live_bcd  (live_bcd),
        .msg_bcd   (msg_bcd),
        .msg_req   (msg_req),
        .msg_cancel(msg_cancel),
        .msg_ack   (msg_ack),
        .msg_done  (msg_done),
        .msg_active(msg_active),
        .frame_tick(frame_tick),
        .bcd_out   (bcd_out)
    );

    always #5 clk = ~clk;

    // smallest frame-end cycle at or after c
    function automatic int next_tick(input int c);
        return c + (FRAME - 1 - (c % FRAME));
    endfunction

    // Evaluate the model on the inputs of the current cycle, then step one clock.
    task automatic adv();
        int k_nxt;
        e_ack  = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_has = 1'b0;
            e_act = 1'b0;
            e_bcd = '0;
            k_nxt = 0;
        end else begin
            if (!m_has) begin
                if (msg_req) begin
                    m_has   = 1'b1;
                    m_msg   = msg_bcd;
                    m_first = next_tick(k + 1) + 1;
                    m_last  = m_first + HOLD * FRAME - 1;
                    e_ack   = 1'b1;
                end
            end else if (k < m_first) begin
                if (msg_cancel) begin
                    m_has  = 1'b0;
                    e_done = 1'b1;
                end
            end else begin
                if (msg_cancel && next_tick(k) < m_last) m_last = next_tick(k);
                if (k == m_last) begin
                    m_has  = 1'b0;
                    e_done = 1'b1;
                end
            end
            e_act = m_has && (k + 1 >= m_first) && (k + 1 <= m_last);
            e_bcd = e_act ? m_msg : live_bcd;
            k_nxt = k + 1;
        end
        @(posedge clk);
        #1;
        k = k_nxt;
    endtask

    // run until the model is idle again
    task automatic drain();
        int guard = 0;
        msg_req    = 1'b0;
        msg_cancel = 1'b0;
        while ((m_has || msg_active) && guard < 100) begin
            adv();
            guard++;
        end
        n_vec++;
        if (guard >= 100) begin
            n_err++;
            $display("FAIL drain_timeout: still busy after %0d cycles, want idle", guard);
        end
    endtask

    task automatic align(input int phase);
        int guard = 0;
        while ((k % FRAME) != phase && guard < 2 * FRAME) begin
            live_bcd = 16'($urandom);
            adv();
            guard++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        live_bcd = 16'h1234;
        adv();
        adv();
        n_vec++;
        if (bcd_out !== 16'h0000) begin n_err++; $display("FAIL reset_bcd: got %h want 0000", bcd_out); end
        n_vec++;
        if (msg_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", msg_active); end
        n_vec++;
        if ({msg_ack, msg_done} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {msg_ack, msg_done}); end
        n_vec++;
        if (frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        rst = 1'b0;
        adv();
        n_vec++;
        if (bcd_out !== 16'h1234) begin n_err++; $display("FAIL live_latency: got %h want 1234", bcd_out); end
        n_vec++;
        if (msg_active !== 1'b0) begin n_err++; $display("FAIL live_active: got %b want 0", msg_active); end
        for (int i = 0; i < FRAME + 2; i++) begin
            live_bcd = 16'($urandom);
            adv();
            n_vec++;
            if (frame_tick !== ((k % FRAME) == FRAME - 1)) begin
                n_err++;
                $display("FAIL frame_tick_k%0d: got %b want %b", k, frame_tick, (k % FRAME) == FRAME - 1);
            end
            n_vec++;
            if (bcd_out !== e_bcd) begin n_err++; $display("FAIL live_follow_k%0d: got %h want %h", k, bcd_out, e_bcd); end
        end
    endtask

    task automatic test_basic_msg();
        int msg_cycles = 0;
        int dones = 0;
        int first_k = -1;
        int guard = 0;
        align(3);
        msg_bcd = 16'h9999;
        msg_req = 1'b1;
        adv();
        n_vec++;
        if (msg_ack !== 1'b1) begin n_err++; $display("FAIL basic_ack: got %b want 1", msg_ack); end
        msg_req = 1'b0;
        while (dones == 0 && guard < 60) begin
            live_bcd = 16'($urandom);
            adv();
            guard++;
            n_vec++;
            if (bcd_out !== e_bcd) begin n_err++; $display("FAIL basic_bcd_k%0d: got %h want %h", k, bcd_out, e_bcd); end
            if (msg_active) begin
                msg_cycles++;
                if (first_k < 0) first_k = k;
            end
            if (msg_done) dones++;
        end
        n_vec++;
        if (msg_cycles != HOLD * FRAME) begin n_err++; $display("FAIL basic_len: got %0d want %0d", msg_cycles, HOLD * FRAME); end
        n_vec++;
        if (first_k % FRAME != 0) begin n_err++; $display("FAIL basic_start_phase: got %0d want 0", first_k % FRAME); end
        n_vec++;
        if (dones != 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", dones); end
        drain();
    endtask

    task automatic test_req_held();
        int acks = 0;
        int exp_acks = 0;
        int last_done_k = -100;
        msg_req = 1'b1;
        msg_bcd = 16'h4321;
        for (int i = 0; i < 70; i++) begin
            live_bcd = 16'($urandom);
            adv();
            if (e_ack) exp_acks++;
            n_vec++;
            if (msg_ack !== e_ack) begin n_err++; $display("FAIL held_ack_k%0d: got %b want %b", k, msg_ack, e_ack); end
            n_vec++;
            if (bcd_out !== e_bcd) begin n_err++; $display("FAIL held_bcd_k%0d: got %h want %h", k, bcd_out, e_bcd); end
            if (msg_ack) begin
                acks++;
                if (last_done_k >= 0) begin
                    n_vec++;
                    if (k != last_done_k + 1) begin n_err++; $display("FAIL held_reack: got k=%0d want %0d", k, last_done_k + 1); end
                end
            end
            if (msg_done) last_done_k = k;
        end
        n_vec++;
        if (acks != exp_acks) begin n_err++; $display("FAIL held_ack_count: got %0d want %0d", acks, exp_acks); end
        drain();
    endtask

    task automatic test_cancel_pend();
        align(0);
        msg_bcd = 16'h5555;
        msg_req = 1'b1;
        adv();
        n_vec++;
        if (msg_ack !== 1'b1) begin n_err++; $display("FAIL cpend_ack: got %b want 1", msg_ack); end
        msg_req = 1'b0;
        msg_cancel = 1'b1;
        adv();
        msg_cancel = 1'b0;
        n_vec++;
        if (msg_done !== 1'b1) begin n_err++; $display("FAIL cpend_done: got %b want 1", msg_done); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            live_bcd = 16'($urandom);
            adv();
            n_vec++;
            if (msg_active !== 1'b0 || msg_done !== 1'b0 || bcd_out !== e_bcd) begin
                n_err++;
                $display("FAIL cpend_quiet_k%0d: got act=%b done=%b bcd=%h want 0 0 %h", k, msg_active, msg_done, bcd_out, e_bcd);
            end
        end
    endtask

    // cancel_at: visible-cycle count at which cancel is raised
    task automatic test_cancel_show(input int cancel_at, input int want_len);
        int msg_cycles = 0;
        int dones = 0;
        int guard = 0;
        align(5);
        msg_bcd = 16'h7788;
        msg_req = 1'b1;
        adv();
        msg_req = 1'b0;
        while (guard < 60) begin
            live_bcd = 16'($urandom);
            adv();
            guard++;
            msg_cancel = 1'b0;
            n_vec++;
            if (bcd_out !== e_bcd) begin n_err++; $display("FAIL cshow_bcd_k%0d: got %h want %h", k, bcd_out, e_bcd); end
            if (msg_done) dones++;
            if (msg_active) begin
                msg_cycles++;
                if (msg_cycles == cancel_at) msg_cancel = 1'b1;
            end
        end
        n_vec++;
        if (msg_cycles != want_len) begin n_err++; $display("FAIL cshow_len_%0d: got %0d want %0d", cancel_at, msg_cycles, want_len); end
        n_vec++;
        if (dones != 1) begin n_err++; $display("FAIL cshow_done_count_%0d: got %0d want 1", cancel_at, dones); end
        drain();
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        msg_bcd = 16'h2468;
        msg_req = 1'b1;
        adv();
        msg_req = 1'b0;
        while (!(msg_active && (k % FRAME) == FRAME - 1) && guard < 40) begin
            adv();
            guard++;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (frame_tick !== 1'b0) begin n_err++; $display("FAIL rstmid_tick_gate: got %b want 0", frame_tick); end
        adv();
        rst = 1'b0;
        n_vec++;
        if (bcd_out !== 16'h0000 || msg_active !== 1'b0 || msg_done !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got bcd=%h act=%b done=%b want 0000 0 0", bcd_out, msg_active, msg_done);
        end
        for (int i = 1; i <= FRAME + 4; i++) begin
            live_bcd = 16'($urandom);
            adv();
            n_vec++;
            if (msg_done !== 1'b0 || msg_active !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_quiet_%0d: got done=%b act=%b want 0 0", i, msg_done, msg_active);
            end
            n_vec++;
            if (frame_tick !== (i == FRAME - 1)) begin
                n_err++;
                $display("FAIL rstmid_restart_%0d: got tick=%b want %b", i, frame_tick, i == FRAME - 1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            live_bcd   = 16'($urandom);
            msg_bcd    = 16'($urandom);
            msg_req    = ($urandom_range(3) == 0);
            msg_cancel = ($urandom_range(23) == 0);
            rst        = ($urandom_range(399) == 0);
            adv();
            n_vec++;
            if (bcd_out !== e_bcd) begin n_err++; $display("FAIL rnd_bcd_%0d: got %h want %h", i, bcd_out, e_bcd); end
            n_vec++;
            if (msg_active !== e_act) begin n_err++; $display("FAIL rnd_active_%0d: got %b want %b", i, msg_active, e_act); end
            n_vec++;
            if (msg_ack !== e_ack) begin n_err++; $display("FAIL rnd_ack_%0d: got %b want %b", i, msg_ack, e_ack); end
            n_vec++;
            if (msg_done !== e_done) begin n_err++; $display("FAIL rnd_done_%0d: got %b want %b", i, msg_done, e_done); end
            n_vec++;
            if (frame_tick !== (!rst && (k % FRAME) == FRAME - 1)) begin
                n_err++;
                $display("FAIL rnd_tick_%0d: got %b want %b", i, frame_tick, !rst && (k % FRAME) == FRAME - 1);
            end
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_msg();
        test_req_held();
        test_cancel_pend();
        test_cancel_show(1, FRAME);
        test_cancel_show(HOLD * FRAME, HOLD * FRAME);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
